uart_rx_fifo: RTL and testbench

//   UART receive front end for the CPU data-memory UART port. Deserialises 8N1 serial

---
 rtl/uart_rx_fifo_if.sv | 49 ++++
 rtl/uart_rx_fifo.sv | 180 ++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_if.sv
// Bus between the UART receive front end and its consumer (data_memory).
// The slave modport is the receiver side; the master modport is the consumer side.
// Optional status wires exist only when UART_RX_STATUS_EN is defined.
// Handshake: a pop is accepted on a clock edge where rdreq=1 and empty=0 are both
// sampled; q carries that byte from the following cycle and holds it until the next
// accepted pop. rdreq with empty=1 is ignored.
interface uart_rx_fifo_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic                  rxd;
    logic                  rdreq;
    logic [7:0]            q;
    logic                  empty;
    logic                  full;
    logic [DEPTH_LOG2:0]   usedw;
    logic [2:0]            dbg_state;
`ifdef UART_RX_STATUS_EN
    logic                  frame_err;
    logic                  overrun;
`endif

    modport slave (
        input  rxd,
        input  rdreq,
        output q,
        output empty,
        output full,
        output usedw,
`ifdef UART_RX_STATUS_EN
        output frame_err,
        output overrun,
`endif
        output dbg_state
    );

    modport master (
        output rxd,
        output rdreq,
        input  q,
        input  empty,
        input  full,
        input  usedw,
`ifdef UART_RX_STATUS_EN
        input  frame_err,
        input  overrun,
`endif
        input  dbg_state
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver feeding a normal-timing (non-show-ahead) byte FIFO.
// Optional sticky status outputs frame_err/overrun: define UART_RX_STATUS_EN.
// dbg_state exposes the receive FSM state for observation.
module uart_rx_fifo #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115_200,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic             clk,
    input  logic             rst,
    uart_rx_fifo_if.slave    bus
);
    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int DEPTH        = 2 ** DEPTH_LOG2;
    localparam logic [CNT_W-1:0] C_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    logic             r_sync1, r_rxd_s;
    state_t           r_state, w_state_n;
    logic [CNT_W-1:0] r_cnt, w_cnt_n;
    logic [2:0]       r_idx, w_idx_n;
    logic [7:0]       r_sh, w_sh_n;
    logic             w_push, w_ferr;

    logic [7:0]          r_mem [DEPTH];
    logic [DEPTH_LOG2:0] r_wr, r_rd, w_wr_n, w_rd_n;
    logic [7:0]          r_q;
    logic                r_empty, r_full;
    logic [DEPTH_LOG2:0] r_usedw;
    logic                w_push_ok, w_pop_ok;

    // Two-flop synchroniser for the asynchronous serial input (idles high).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_rxd_s <= 1'b1;
        end else begin
            r_sync1 <= bus.rxd;
            r_rxd_s <= r_sync1;
        end
    end

    // Receive FSM state, bit timer, bit index and shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_sh    <= '0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_idx   <= w_idx_n;
            r_sh    <= w_sh_n;
        end
    end

    // Next-state logic; the timer restarts at 0 whenever a state is (re)entered,
    // and data/stop samples fall one full bit period apart from mid start bit.
    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt + 1'b1;
        w_idx_n   = r_idx;
        w_sh_n    = r_sh;
        w_push    = 1'b0;
        w_ferr    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_n = '0;
                if (!r_rxd_s) w_state_n = S_START;
            end
            S_START: begin
                if (r_cnt == C_MID) begin
                    w_cnt_n = '0;
                    if (!r_rxd_s) begin
                        w_state_n = S_DATA;
                        w_idx_n   = '0;
                    end else begin
                        w_state_n = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (r_cnt == C_LAST) begin
                    w_cnt_n = '0;
                    w_sh_n  = {r_rxd_s, r_sh[7:1]};
                    if (r_idx == 3'd7) w_state_n = S_STOP;
                    else               w_idx_n   = r_idx + 3'd1;
                end
            end
            S_STOP: begin
                if (r_cnt == C_LAST) begin
                    w_cnt_n = '0;
                    if (r_rxd_s) begin
                        w_push    = 1'b1;
                        w_state_n = S_IDLE;
                    end else begin
                        w_ferr    = 1'b1;
                        w_state_n = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                w_cnt_n = '0;
                if (r_rxd_s) w_state_n = S_IDLE;
            end
            default: begin
                w_state_n = S_IDLE;
                w_cnt_n   = '0;
            end
        endcase
    end

    // Push is refused while full; pop is refused while empty (flags from this cycle).
    assign w_push_ok = w_push && !r_full;
    assign w_pop_ok  = bus.rdreq && !r_empty;
    assign w_wr_n    = r_wr + {{DEPTH_LOG2{1'b0}}, w_push_ok};
    assign w_rd_n    = r_rd + {{DEPTH_LOG2{1'b0}}, w_pop_ok};

    // FIFO storage; stale contents are harmless because the pointers gate reads.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr[DEPTH_LOG2-1:0]] <= r_sh;
    end

    // Pointers, output byte and status flags derived from the next pointer values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_q     <= '0;
            r_empty <= 1'b1;
            r_full  <= 1'b0;
            r_usedw <= '0;
        end else begin
            r_wr    <= w_wr_n;
            r_rd    <= w_rd_n;
            if (w_pop_ok) r_q <= r_mem[r_rd[DEPTH_LOG2-1:0]];
            r_empty <= (w_wr_n == w_rd_n);
            r_full  <= (w_wr_n[DEPTH_LOG2] != w_rd_n[DEPTH_LOG2]) &&
                       (w_wr_n[DEPTH_LOG2-1:0] == w_rd_n[DEPTH_LOG2-1:0]);
            r_usedw <= w_wr_n - w_rd_n;
        end
    end

`ifdef UART_RX_STATUS_EN
    logic r_frame_err, r_overrun;

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_ferr)            r_frame_err <= 1'b1;
            if (w_push && r_full)  r_overrun   <= 1'b1;
        end
    end

    assign bus.frame_err = r_frame_err;
    assign bus.overrun   = r_overrun;
`else
    logic w_unused_ferr;
    assign w_unused_ferr = w_ferr;
`endif

    assign bus.q         = r_q;
    assign bus.empty     = r_empty;
    assign bus.full      = r_full;
    assign bus.usedw     = r_usedw;
    assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: 10 clocks per bit, 4-entry FIFO.
// Expected bytes go into a queue when a frame is sent; a monitor pops and
// compares each byte the DUT delivers on q.
module tb_uart_rx_fifo;
  localparam int CPB = 10;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];

  uart_rx_fifo_if #(.DEPTH_LOG2(2)) bus ();

  uart_rx_fifo #(
    .CLK_HZ(1_000_000),
    .BAUD(100_000),
    .DEPTH_LOG2(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver: one 8N1 frame, stop bit level selectable
  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk);
    bus.rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
    bus.rxd = stop;
    repeat (CPB) @(negedge clk);
    bus.rxd = 1'b1;
  endtask

  // scoreboard entry for a good frame; a full FIFO drops it
  task automatic expect_byte(input logic [7:0] b);
    if (exp_q.size() < DEPTH) exp_q.push_back(b);
  endtask

  task automatic pop_one();
    @(negedge clk);
    bus.rdreq = 1'b1;
    @(negedge clk);
    bus.rdreq = 1'b0;
  endtask

  // monitor: every accepted pop delivers the next expected byte one edge later
  always @(posedge clk) begin
    if (!rst && bus.rdreq && !bus.empty) begin
      #1;
      if (exp_q.size() == 0) begin
        chk("unexpected_pop", 32'(bus.q), 32'hFFFF_FFFF);
      end else begin
        chk("q_byte", 32'(bus.q), 32'(exp_q.pop_front()));
      end
    end
  end

  int lat;

  initial begin
    bus.rxd = 1'b1;
    bus.rdreq = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_q", 32'(bus.q), 32'h0);
    chk("rst_empty", 32'(bus.empty), 32'h1);
    chk("rst_full", 32'(bus.full), 32'h0);
    chk("rst_usedw", 32'(bus.usedw), 32'h0);
    chk("rst_state", 32'(bus.dbg_state), 32'h0);

    // rdreq held while empty, then 0x3C arrives
    bus.rdreq = 1'b1;
    repeat (20) @(negedge clk);
    chk("hold_q", 32'(bus.q), 32'h0);
    chk("hold_usedw", 32'(bus.usedw), 32'h0);
    expect_byte(8'h3C);
    send_byte(8'h3C, 1'b1);
    repeat (5) @(negedge clk);
    bus.rdreq = 1'b0;
    chk("hold_q_3c", 32'(bus.q), 32'h3C);
    chk("hold_usedw_after", 32'(bus.usedw), 32'h0);
    chk("hold_empty_after", 32'(bus.empty), 32'h1);
    chk("hold_drained", 32'(exp_q.size()), 32'h0);

    // single byte and its latency
    expect_byte(8'hA5);
    lat = 0;
    fork
      send_byte(8'hA5, 1'b1);
      begin
        while (bus.empty && lat < 200) begin
          @(negedge clk);
          lat++;
        end
      end
    join
    chk("a5_latency_ok", 32'((lat >= 85) && (lat <= 110)), 32'h1);
    chk("a5_usedw", 32'(bus.usedw), 32'h1);
    pop_one();
    @(negedge clk);
    chk("a5_empty", 32'(bus.empty), 32'h1);

    // four back-to-back bytes fill the FIFO
    expect_byte(8'h01); send_byte(8'h01, 1'b1);
    expect_byte(8'h80); send_byte(8'h80, 1'b1);
    expect_byte(8'hFF); send_byte(8'hFF, 1'b1);
    expect_byte(8'h00); send_byte(8'h00, 1'b1);
    chk("fill_full", 32'(bus.full), 32'h1);
    chk("fill_usedw", 32'(bus.usedw), 32'h4);
    repeat (4) pop_one();
    @(negedge clk);
    chk("fill_empty", 32'(bus.empty), 32'h1);

    // five bytes, the fifth dropped
    expect_byte(8'h11); send_byte(8'h11, 1'b1);
    expect_byte(8'h22); send_byte(8'h22, 1'b1);
    expect_byte(8'h33); send_byte(8'h33, 1'b1);
    expect_byte(8'h44); send_byte(8'h44, 1'b1);
    expect_byte(8'h55); send_byte(8'h55, 1'b1);
    chk("ovr_full", 32'(bus.full), 32'h1);
    chk("ovr_usedw", 32'(bus.usedw), 32'h4);
`ifdef UART_RX_STATUS_EN
    chk("ovr_flag", 32'(bus.overrun), 32'h1);
`endif
    repeat (4) pop_one();
    @(negedge clk);
    chk("ovr_empty", 32'(bus.empty), 32'h1);
    chk("ovr_drained", 32'(exp_q.size()), 32'h0);

    // 3-clock glitch in idle
    @(negedge clk);
    bus.rxd = 1'b0;
    repeat (3) @(negedge clk);
    bus.rxd = 1'b1;
    repeat (30) @(negedge clk);
    chk("glitch_empty", 32'(bus.empty), 32'h1);
    chk("glitch_state", 32'(bus.dbg_state), 32'h0);

    // framing error: stop bit low
    send_byte(8'h77, 1'b0);
    repeat (2 * CPB) @(negedge clk);
    chk("ferr_empty", 32'(bus.empty), 32'h1);
    chk("ferr_state", 32'(bus.dbg_state), 32'h0);
`ifdef UART_RX_STATUS_EN
    chk("ferr_flag", 32'(bus.frame_err), 32'h1);
`endif

    // reset mid-frame with a byte already buffered
    expect_byte(8'h12);
    send_byte(8'h12, 1'b1);
    chk("pre_rst_usedw", 32'(bus.usedw), 32'h1);
    @(negedge clk);
    bus.rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    bus.rxd = 1'b1;
    repeat (CPB) @(negedge clk);
    bus.rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    chk("mid_state_data", 32'(bus.dbg_state), 32'h2);
    rst = 1'b1;
    exp_q.delete();
    repeat (3) @(negedge clk);
    bus.rxd = 1'b1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_rst_empty", 32'(bus.empty), 32'h1);
    chk("mid_rst_usedw", 32'(bus.usedw), 32'h0);
`ifdef UART_RX_STATUS_EN
    chk("mid_rst_ferr", 32'(bus.frame_err), 32'h0);
`endif
    expect_byte(8'h5A);
    send_byte(8'h5A, 1'b1);
    repeat (CPB) @(negedge clk);
    chk("mid_rst_usedw1", 32'(bus.usedw), 32'h1);
    pop_one();
    @(negedge clk);
    chk("mid_rst_final_empty", 32'(bus.empty), 32'h1);
    chk("final_drained", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
